// File: rtl/stepmania_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package stepmania_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIR_W  = 4;

    // Set-2 make codes for the four arrows on the main block
    localparam logic [BYTE_W-1:0] KEY_LEFT  = 8'h34;
    localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h33;
    localparam logic [BYTE_W-1:0] KEY_UP    = 8'h35;
    localparam logic [BYTE_W-1:0] KEY_RIGHT = 8'h3B;

    // Set-2 codes for the cursor keys, sent after the E0 prefix
    localparam logic [BYTE_W-1:0] EXT_LEFT  = 8'h6B;
    localparam logic [BYTE_W-1:0] EXT_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] EXT_UP    = 8'h75;
    localparam logic [BYTE_W-1:0] EXT_RIGHT = 8'h74;

    // Prefix bytes
    localparam logic [BYTE_W-1:0] PS2_BREAK = 8'hF0;
    localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;

    // Frame receiver state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // One-hot direction bit for a scan code ({right, up, down, left}); zero when unmapped
    function automatic logic [DIR_W-1:0] dir_mask(input logic [BYTE_W-1:0] code,
                                                   input logic             ext);
        dir_mask = '0;
        if (ext) begin
            case (code)
                EXT_LEFT:  dir_mask = 4'b0001;
                EXT_DOWN:  dir_mask = 4'b0010;
                EXT_UP:    dir_mask = 4'b0100;
                EXT_RIGHT: dir_mask = 4'b1000;
                default:   dir_mask = 4'b0000;
            endcase
        end else begin
            case (code)
                KEY_LEFT:  dir_mask = 4'b0001;
                KEY_DOWN:  dir_mask = 4'b0010;
                KEY_UP:    dir_mask = 4'b0100;
                KEY_RIGHT: dir_mask = 4'b1000;
                default:   dir_mask = 4'b0000;
            endcase
        end
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit frame FSM and watchdog.
module ps2_rx_frame
    import stepmania_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    output logic              code_valid,
    output logic [BYTE_W-1:0] code_byte,
    output logic              frame_err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = 3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   data_s;
    logic                   fall_c;

    frame_state_t           state;
    frame_state_t           state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       bit_cnt_nxt;
    logic [BYTE_W-1:0]      shift;
    logic [BYTE_W-1:0]      shift_nxt;
    logic                   parity_bit;
    logic                   parity_nxt;
    logic [WD_W-1:0]        wd;
    logic [WD_W-1:0]        wd_nxt;
    logic                   valid_nxt;
    logic [BYTE_W-1:0]      byte_nxt;
    logic                   err_nxt;

    // Synchronizer chains idle high, matching the released bus
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev  <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign fall_c    = clk_prev & ~ps2_clk_s;

    // Frame state, shift register, watchdog and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            wd         <= '0;
            code_valid <= 1'b0;
            code_byte  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            parity_bit <= parity_nxt;
            wd         <= wd_nxt;
            code_valid <= valid_nxt;
            code_byte  <= byte_nxt;
            frame_err  <= err_nxt;
        end
    end

    // One FSM step per falling edge; otherwise the watchdog runs while a frame is open.
    // The watchdog holds "cycles since the last edge", so it reaches TIMEOUT_CYCLES
    // exactly when the abandon takes effect.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        parity_nxt  = parity_bit;
        wd_nxt      = wd;
        valid_nxt   = 1'b0;
        byte_nxt    = code_byte;
        err_nxt     = 1'b0;

        if (fall_c) begin
            wd_nxt = WD_W'(1);
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt   = {data_s, shift[BYTE_W-1:1]};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    parity_nxt = data_s;
                    state_nxt  = STOP;
                end
                STOP: begin
                    if (data_s && ((^shift) ^ parity_bit)) begin
                        valid_nxt = 1'b1;
                        byte_nxt  = shift;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (wd != WD_W'(TIMEOUT_CYCLES)) begin
                wd_nxt = wd + WD_W'(1);
            end
            if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_nxt = IDLE;
                shift_nxt = '0;
                err_nxt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard front end: frame receiver plus break/extended prefix decode into keycode and held mask.
module ps2_keycode
    import stepmania_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    output logic [BYTE_W-1:0] keycode,
    output logic [DIR_W-1:0]  key_held,
    output logic              code_valid,
    output logic [BYTE_W-1:0] code_byte,
    output logic              frame_err
);

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_err;

    logic              brk;
    logic              brk_nxt;
    logic              ext;
    logic              ext_nxt;
    logic [BYTE_W-1:0] keycode_nxt;
    logic [DIR_W-1:0]  held_nxt;
    logic [DIR_W-1:0]  mask;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .code_valid (rx_valid),
        .code_byte  (rx_byte),
        .frame_err  (rx_err)
    );

    assign code_valid = rx_valid;
    assign code_byte  = rx_byte;
    assign frame_err  = rx_err;

    // Prefix flags and decoded key state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            brk      <= 1'b0;
            ext      <= 1'b0;
            keycode  <= '0;
            key_held <= '0;
        end else begin
            brk      <= brk_nxt;
            ext      <= ext_nxt;
            keycode  <= keycode_nxt;
            key_held <= held_nxt;
        end
    end

    // Prefixes only arm flags; the following byte is a make or break and consumes both flags
    always_comb begin
        brk_nxt     = brk;
        ext_nxt     = ext;
        keycode_nxt = keycode;
        held_nxt    = key_held;
        mask        = dir_mask(rx_byte, ext);

        if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_nxt = 1'b1;
            end else if (rx_byte == PS2_BREAK) begin
                brk_nxt = 1'b1;
            end else begin
                brk_nxt = 1'b0;
                ext_nxt = 1'b0;
                if (brk) begin
                    held_nxt = key_held & ~mask;
                end else begin
                    held_nxt = key_held | mask;
                end
                if (!ext) begin
                    if (!brk) begin
                        keycode_nxt = rx_byte;
                    end else if (rx_byte == keycode) begin
                        keycode_nxt = '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: directed scenarios plus random byte streams against a scan-code model.
module tb_ps2_keycode;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 20;

    logic       Clk;
    logic       Reset;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] keycode;
    logic [3:0] key_held;
    logic       code_valid;
    logic [7:0] code_byte;
    logic       frame_err;

    int tests;
    int fails;
    int valid_cnt;
    int err_cnt;
    logic [7:0] last_byte;

    // Reference model state
    logic [7:0] m_key;
    logic [3:0] m_held;
    bit         m_brk;
    bit         m_ext;
    logic [7:0] dir_codes [8];

    int  n;
    bit  found;
    int  r;
    logic [7:0] b;

    ps2_keycode #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .keycode    (keycode),
        .key_held   (key_held),
        .code_valid (code_valid),
        .code_byte  (code_byte),
        .frame_err  (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse monitor
    always @(negedge Clk) begin
        if (code_valid) begin
            valid_cnt = valid_cnt + 1;
            last_byte = code_byte;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Direction index of a code (0..3) or -1, from the arrow code table
    function automatic int dir_of(input logic [7:0] c, input bit e);
        dir_of = -1;
        for (int i = 0; i < 8; i++) begin
            if (dir_codes[i] == c && ((i >= 4) == e)) dir_of = i % 4;
        end
    endfunction

    task automatic model_reset();
        m_key  = 8'h00;
        m_held = 4'b0000;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        int d;
        if (c == 8'hE0) begin
            m_ext = 1'b1;
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            d = dir_of(c, m_ext);
            if (d >= 0) m_held[d] = !m_brk;
            if (!m_ext) begin
                if (!m_brk) m_key = c;
                else if (c == m_key) m_key = 8'h00;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge Clk);
        PS2_DATA = v;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i]);
        ps2_bit((~^v) ^ bad_par);
        ps2_bit(~bad_stop);
        PS2_DATA = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    // Clean frame: one accept with the right byte, no error, model-matching key state
    task automatic good_frame(input logic [7:0] v, input string tag);
        valid_cnt = 0;
        err_cnt   = 0;
        send_frame(v, 1'b0, 1'b0);
        model_byte(v);
        check({tag, "_valid_cnt"}, valid_cnt, 1);
        check({tag, "_byte"},      last_byte, v);
        check({tag, "_err_cnt"},   err_cnt, 0);
        check({tag, "_keycode"},   keycode, m_key);
        check({tag, "_held"},      key_held, m_held);
    endtask

    task automatic bad_frame(input logic [7:0] v, input string tag);
        valid_cnt = 0;
        err_cnt   = 0;
        send_frame(v, 1'b1, 1'b0);
        check({tag, "_err_cnt"},   err_cnt, 1);
        check({tag, "_valid_cnt"}, valid_cnt, 0);
        check({tag, "_keycode"},   keycode, m_key);
        check({tag, "_held"},      key_held, m_held);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        last_byte = 8'h00;
        dir_codes = '{8'h34, 8'h33, 8'h35, 8'h3B, 8'h6B, 8'h72, 8'h75, 8'h74};
        Reset     = 1'b1;
        PS2_CLK   = 1'b1;
        PS2_DATA  = 1'b1;
        model_reset();

        // Reset state
        repeat (4) @(negedge Clk);
        check("rst_keycode",    keycode, 8'h00);
        check("rst_held",       key_held, 4'h0);
        check("rst_code_valid", code_valid, 1'b0);
        check("rst_code_byte",  code_byte, 8'h00);
        check("rst_frame_err",  frame_err, 1'b0);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);

        // Single make
        good_frame(8'h34, "make34");
        check("make34_key_const",  keycode, 8'h34);
        check("make34_held_const", key_held, 4'b0001);

        // Second make then release of the first
        good_frame(8'h3B, "make3b");
        check("make3b_key_const",  keycode, 8'h3B);
        check("make3b_held_const", key_held, 4'b1001);
        good_frame(8'hF0, "brk_pfx");
        good_frame(8'h34, "brk34");
        check("brk34_key_const",  keycode, 8'h3B);
        check("brk34_held_const", key_held, 4'b1000);

        // Parity error after reset
        do_reset();
        bad_frame(8'h33, "par33");
        check("par33_key_const", keycode, 8'h00);

        // Extended up press and release
        good_frame(8'hE0, "ext_pfx1");
        good_frame(8'h75, "ext75_make");
        check("ext75_held_const", key_held, 4'b0100);
        check("ext75_key_const",  keycode, 8'h00);
        good_frame(8'hE0, "ext_pfx2");
        good_frame(8'hF0, "ext_brk_pfx");
        good_frame(8'h75, "ext75_brk");
        check("ext75b_held_const", key_held, 4'b0000);
        check("ext75b_key_const",  keycode, 8'h00);

        // Watchdog: start plus four data bits, then the clock stops
        valid_cnt = 0;
        err_cnt   = 0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge Clk);
        PS2_DATA = 1'b1;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        n     = 0;
        found = 1'b0;
        while (!found && n < int'(SYNC + TMO + 50)) begin
            @(negedge Clk);
            n = n + 1;
            if (n == int'(HALF)) PS2_CLK = 1'b1;
            if (frame_err) found = 1'b1;
        end
        check("tmo_latency", n, SYNC + TMO);
        repeat (TMO + 20) @(negedge Clk);
        check("tmo_err_cnt",   err_cnt, 1);
        check("tmo_valid_cnt", valid_cnt, 0);
        good_frame(8'h35, "post_tmo35");
        check("post_tmo_key_const", keycode, 8'h35);

        // Reset mid-frame while a key is held
        do_reset();
        good_frame(8'h34, "pre_rst34");
        check("pre_rst_held_const", key_held, 4'b0001);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge Clk);
        PS2_DATA = 1'b1;
        Reset    = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        check("midrst_keycode",    keycode, 8'h00);
        check("midrst_held",       key_held, 4'h0);
        check("midrst_code_valid", code_valid, 1'b0);
        check("midrst_code_byte",  code_byte, 8'h00);
        check("midrst_frame_err",  frame_err, 1'b0);
        repeat (4) @(negedge Clk);
        good_frame(8'h34, "post_rst34");
        check("post_rst_key_const",  keycode, 8'h34);
        check("post_rst_held_const", key_held, 4'b0001);

        // Random streams of arrow codes, prefixes, other codes and corrupted frames
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 15));
            if (r < 8)        b = dir_codes[r];
            else if (r == 8)  b = 8'hE0;
            else if (r == 9)  b = 8'hF0;
            else              b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) bad_frame(b, $sformatf("rnd%0d_bad", k));
            else                           good_frame(b, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_keycode.md
Name: ps2_keycode

Overview:
- Receives PS/2 set-2 scan-code frames from the keyboard and publishes the `keycode` byte that the receptor and judging logic consume.
- Also publishes a 4-bit held mask for left/down/up/right, so simultaneous presses (jumps) are visible.
- Sits between the board PS/2 pins and the VGA/game logic, in the `Clk` domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on PS2_CLK and PS2_DATA.
- TIMEOUT_CYCLES, 10000, `Clk` cycles without a PS2_CLK falling edge before a partial frame is abandoned (200 us at 50 MHz).

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- PS2_CLK  input  1  keyboard clock, asynchronous to `Clk`.
- PS2_DATA  input  1  keyboard data, asynchronous to `Clk`.
- keycode  output  8  last non-extended make code still held; 8'h00 when none.
- key_held  output  4  [0]=left, [1]=down, [2]=up, [3]=right; 1 while the key is held.
- code_valid  output  1  one-cycle pulse when a frame byte is accepted.
- code_byte  output  8  raw accepted byte; valid while code_valid is high.
- frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Clock and reset: one clock, `Clk`; reset `Reset` is synchronous and active-high. While Reset is high:
  - keycode=0, key_held=0, code_valid=0, code_byte=0, frame_err=0.
  - Frame FSM returns to IDLE; break and extended prefix flags are cleared.
  - The sync chains load 1 (bus idle level).
- Sampling: PS2_CLK and PS2_DATA each pass through SYNC_STAGES flops. A falling edge is synced-clock previous=1, current=0. Data is sampled on the synced value in the falling-edge cycle.
- Frame FSM (one step per falling edge):
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: accept the byte if stop=1 and (^byte ^ parity)=1 (odd parity). Otherwise pulse frame_err. Either way → IDLE.
- Timeout: a watchdog counter clears on every falling edge and counts while the FSM is not in IDLE. On reaching TIMEOUT_CYCLES → IDLE, one frame_err pulse, and the partial byte is discarded. The counter saturates and does not wrap.
- Accept latency: code_valid and code_byte assert in the cycle after the falling edge that samples the stop bit.
- Decode on each accepted byte:
  - 8'hE0: set ext. keycode and key_held are unchanged.
  - 8'hF0: set brk. keycode and key_held are unchanged.
  - Any other byte C is a make if brk=0 and a break if brk=1. Both brk and ext clear after C is processed.
  - Non-extended make: keycode<=C. C=34/33/35/3B sets key_held bit 0/1/2/3 respectively.
  - Non-extended break: if C==keycode then keycode<=0. The matching key_held bit clears.
  - Extended (ext=1) C=6B/72/75/74 sets (make) or clears (break) key_held bit 0/1/2/3 respectively. Extended codes never change keycode.
  - Unmapped codes affect keycode only.
- Typematic repeats rewrite identical values; this is not an error.
- A framing error does not clear brk or ext.
- Simultaneous events: a timeout and a falling edge in the same cycle → the edge wins and the watchdog clears.

Decomposition:
- stepmania_pkg holds:
  - KEY_LEFT=8'h34, KEY_DOWN=8'h33, KEY_UP=8'h35, KEY_RIGHT=8'h3B.
  - EXT_LEFT=8'h6B, EXT_DOWN=8'h72, EXT_UP=8'h75, EXT_RIGHT=8'h74.
  - PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
  - The frame FSM state enum (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_rx_frame contains the synchronizers, edge detect, frame FSM and watchdog. It outputs code_valid, code_byte and frame_err.
- ps2_keycode wraps ps2_rx_frame and adds the prefix/decode registers.

Test Plan:
- Send frame 8'h34 at a 12.5 kHz PS/2 clock → code_valid once with code_byte=34, keycode=34, key_held=4'b0001.
- Send 8'h34, 8'h3B, then F0,34 → after the second byte keycode=3B, key_held=1001. After the release keycode=3B (34≠3B) and key_held=1000.
- Send 8'h33 with the parity bit inverted → frame_err pulse, no code_valid, keycode unchanged at 00.
- Send E0,75, then E0,F0,75 → key_held bit 2 sets then clears, keycode stays 00.
- Stop PS2_CLK after 4 data bits → frame_err exactly TIMEOUT_CYCLES cycles after the last edge. A following clean 8'h35 frame decodes to keycode=35.
- Assert Reset for one cycle mid-frame while key_held=0001 → all outputs 0 next cycle. A fresh 8'h34 frame decodes normally.
